double_sha256: RTL and testbench



---
 rtl/sha256_pkg.sv | 63 ++++++
 rtl/double_sha256_if.sv | 17 +
 rtl/sha256_round.sv | 29 ++
 rtl/double_sha256.sv | 163 ++++++++++++++++
 tb/tb_double_sha256.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// ============================================================================
//  sha256_pkg
//  SHA-256 constants, padding words, FSM state type and round helper functions.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

  localparam logic [31:0] c_k [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] c_h_init = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Tail of the second pass-1 block (640-bit message) and of the pass-2 block (256-bit message)
  localparam logic [383:0] c_pad1 = {32'h80000000, 320'h0, 32'h00000280};
  localparam logic [255:0] c_pad2 = {32'h80000000, 192'h0, 32'h00000100};

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ROUND = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/double_sha256_if.sv
// ============================================================================
//  double_sha256_if
//  Header in / digest out bundle between the hashcore (master) and a lane (slave).
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface double_sha256_if;
  logic [639:0] block_info;
  logic         complete;
  logic [255:0] hash;

  modport master (output block_info, input complete, input hash);
  modport slave  (input block_info, output complete, output hash);
endinterface

`default_nettype wire

// File: rtl/sha256_round.sv
// ============================================================================
//  sha256_round
//  One combinational SHA-256 round: {a..h} in, {a..h} out, packed a in [255:224].
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] i_state,
  input  logic [31:0]  i_w,
  input  logic [31:0]  i_k,
  output logic [255:0] o_state
);

  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0] w_t1, w_t2;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

  assign w_t1 = w_h + Sigma1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
  assign w_t2 = Sigma0(w_a) + maj(w_a, w_b, w_c);

  assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

`default_nettype wire

// File: rtl/double_sha256.sv
// ============================================================================
//  double_sha256
//  SHA256(SHA256(header)) of an 80-byte header, iterative, one lane.
//  Build option: SHA_UNROLL2_EN -> two rounds per clock (102-edge latency).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module double_sha256
  import sha256_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  double_sha256_if.slave bus
);

`ifdef SHA_UNROLL2_EN
  localparam logic [5:0] c_step = 6'd2;
  localparam logic [5:0] c_last = 6'd62;
`else
  localparam logic [5:0] c_step = 6'd1;
  localparam logic [5:0] c_last = 6'd63;
`endif

  state_t       r_state, w_state_next;
  logic [639:0] r_msg;
  logic [1:0]   r_blk;
  logic [5:0]   r_round;
  logic [255:0] r_h;
  logic [255:0] r_work;
  logic [31:0]  r_w [0:15];
  logic [255:0] r_hash;
  logic         r_complete;

  logic         w_do_load, w_do_round, w_do_add, w_last_blk;
  logic [511:0] w_block;
  logic [255:0] w_chain, w_sum, w_round0, w_next_work;
  logic [31:0]  w_w_new0;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= LOAD;
    else       r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD:    w_state_next = ROUND;
      ROUND:   if (r_round == c_last) w_state_next = ADD;
      ADD:     w_state_next = (r_blk == 2'd2) ? DONE : LOAD;
      DONE:    w_state_next = DONE;
      default: w_state_next = LOAD;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_do_load  = 1'b0;
    w_do_round = 1'b0;
    w_do_add   = 1'b0;
    w_last_blk = (r_blk == 2'd2);
    case (r_state)
      LOAD:    w_do_load  = 1'b1;
      ROUND:   w_do_round = 1'b1;
      ADD:     w_do_add   = 1'b1;
      default: ;
    endcase
  end

  // Compression 1 chains from compression 0; the other two start from the IV
  assign w_chain = (r_blk == 2'd1) ? r_h : c_h_init;

  always_comb begin
    case (r_blk)
      2'd0:    w_block = r_msg[639:128];
      2'd1:    w_block = {r_msg[127:0], c_pad1};
      default: w_block = {r_h, c_pad2};
    endcase
  end

  sha256_round u_round0 (
    .i_state (r_work),
    .i_w     (r_w[0]),
    .i_k     (c_k[r_round]),
    .o_state (w_round0)
  );

  assign w_w_new0 = sigma1(r_w[14]) + r_w[9] + sigma0(r_w[1]) + r_w[0];

`ifdef SHA_UNROLL2_EN
  logic [255:0] w_round1;
  logic [31:0]  w_w_new1;
  logic [5:0]   w_k_idx1;

  assign w_k_idx1 = r_round + 6'd1;

  sha256_round u_round1 (
    .i_state (w_round0),
    .i_w     (r_w[1]),
    .i_k     (c_k[w_k_idx1]),
    .o_state (w_round1)
  );

  assign w_w_new1    = sigma1(r_w[15]) + r_w[10] + sigma0(r_w[2]) + r_w[1];
  assign w_next_work = w_round1;
`else
  assign w_next_work = w_round0;
`endif

  for (genvar gi = 0; gi < 8; gi++) begin : g_sum
    assign w_sum[255-32*gi -: 32] = w_chain[255-32*gi -: 32] + r_work[255-32*gi -: 32];
  end

  // ---------------- control and outputs ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_msg      <= bus.block_info;
      r_blk      <= 2'd0;
      r_round    <= 6'd0;
      r_complete <= 1'b0;
      r_hash     <= '0;
    end else begin
      if (w_do_load)       r_round <= 6'd0;
      else if (w_do_round) r_round <= r_round + c_step;
      if (w_do_add) begin
        if (w_last_blk) begin
          r_hash     <= w_sum;
          r_complete <= 1'b1;
        end else begin
          r_blk <= r_blk + 2'd1;
        end
      end
    end
  end

  // ---------------- datapath (no reset needed) ----------------
  always_ff @(posedge clk_i) begin
    if (w_do_load) begin
      r_work <= w_chain;
      for (int i = 0; i < 16; i++) r_w[i] <= w_block[511-32*i -: 32];
    end
    if (w_do_round) begin
      r_work <= w_next_work;
`ifdef SHA_UNROLL2_EN
      for (int i = 0; i < 14; i++) r_w[i] <= r_w[i+2];
      r_w[14] <= w_w_new0;
      r_w[15] <= w_w_new1;
`else
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_w_new0;
`endif
    end
    if (w_do_add) r_h <= w_sum;
  end

  assign bus.complete = r_complete;
  assign bus.hash     = r_hash;

endmodule

`default_nettype wire

// File: tb/tb_double_sha256.sv
// ============================================================================
//  tb_double_sha256
//  Directed checks of double_sha256 against the genesis digest and a SHA-256 model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_double_sha256;

`ifdef SHA_UNROLL2_EN
  localparam int LAT = 102;
`else
  localparam int LAT = 198;
`endif

  localparam logic [31:0] TB_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] TB_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [639:0] GENESIS = {
    32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c
  };
  localparam logic [255:0] GENESIS_HASH =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   total = 0;
  int   bad   = 0;

  double_sha256_if bus ();

  double_sha256 dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + TB_K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96]  + e, hin[95:64]   + f, hin[63:32]   + g, hin[31:0]    + h};
  endfunction

  function automatic logic [255:0] dsha(input logic [639:0] hdr);
    logic [1023:0] m;
    logic [255:0]  d;
    m = {hdr, 8'h80, 312'h0, 64'd640};
    d = compress(TB_IV, m[1023:512]);
    d = compress(d, m[511:0]);
    return compress(TB_IV, {d, 8'h80, 184'h0, 64'd256});
  endfunction

  function automatic logic [639:0] rand_hdr();
    logic [639:0] v;
    for (int i = 0; i < 20; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs from release of reset; reports the first edge at which complete is seen high
  task automatic run(input bit jitter, output int first);
    first = -1;
    for (int n = 1; n <= LAT + 5; n++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (first < 0 && bus.complete === 1'b1) first = n;
      if (jitter) bus.block_info = rand_hdr();
    end
  endtask

  logic [639:0] hdr;
  logic [255:0] exp_hash;
  int           first_edge;

  initial begin
    // Reset values
    bus.block_info = GENESIS;
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_complete", 256'(bus.complete), 256'(1'b0));
    check("rst_hash", bus.hash, 256'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_complete_held", 256'(bus.complete), 256'(1'b0));
    rst_i = 1'b0;

    // Genesis header
    run(1'b0, first_edge);
    check("genesis_latency", 256'(first_edge), 256'(LAT));
    check("genesis_hash", bus.hash, GENESIS_HASH);

    // Hold after completion with input changing
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      bus.block_info = rand_hdr();
    end
    @(negedge clk_i);
    check("hold_complete", 256'(bus.complete), 256'(1'b1));
    check("hold_hash", bus.hash, GENESIS_HASH);

    // Mid-operation reset at edge 100
    bus.block_info = {GENESIS[639:32], 32'd0};
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (99) @(negedge clk_i);
    check("mid_busy", 256'(bus.complete), 256'(1'b0));
    hdr = {GENESIS[639:32], 32'd10};
    exp_hash = dsha(hdr);
    bus.block_info = hdr;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_complete", 256'(bus.complete), 256'(1'b0));
    check("mid_rst_hash", bus.hash, 256'h0);
    rst_i = 1'b0;
    run(1'b0, first_edge);
    check("mid_latency", 256'(first_edge), 256'(LAT));
    check("mid_hash_nonce10", bus.hash, exp_hash);

    // Back-to-back restart with input jitter while running
    hdr = {GENESIS[639:32], 32'h12345678};
    exp_hash = dsha(hdr);
    bus.block_info = hdr;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("b2b_rst_complete", 256'(bus.complete), 256'(1'b0));
    rst_i = 1'b0;
    run(1'b1, first_edge);
    check("b2b_latency", 256'(first_edge), 256'(LAT));
    check("b2b_hash", bus.hash, exp_hash);

    // Fully random header captured at the reset edge
    hdr = rand_hdr();
    exp_hash = dsha(hdr);
    bus.block_info = hdr;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    run(1'b1, first_edge);
    check("rand_latency", 256'(first_edge), 256'(LAT));
    check("rand_hash", bus.hash, exp_hash);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
